// File: rtl/pattern_ack_handler.sv
`timescale 1ns/1ps
// pattern_ack_handler
// Consumer of the byte-stream pattern detector. Each time found_pattern is
// seen high in IDLE the match is counted and held. The hold ends either when
// the hold timer expires (auto_mode=1) or on a debounced operator button
// press. The match is then released by toggling ack. A detector that does
// not drop found_pattern within RELEASE_TIMEOUT cycles of the toggle is
// flagged in release_err, and the block waits for the detector in DRAIN.
//
// Ports
//   clk           system clock, rising edge
//   reset_sync    asynchronous active-high reset, clears all state
//   found_pattern detector match level (same clock domain)
//   btn_n         raw active-low pushbutton, asynchronous to clk
//   auto_mode     1: release on hold timer or button, 0: button only
//   clear_count   synchronous clear of match_count, overflow, release_err
//   ack           toggle acknowledge; every level change releases one match
//   match_pulse   one-cycle pulse per accepted match
//   match_count   saturating count of accepted matches
//   busy          high from match acceptance until the detector releases
//   overflow      sticky: a match was accepted while match_count was all-ones
//   release_err   sticky: found_pattern did not fall within RELEASE_TIMEOUT
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for found_pattern high; accepts and counts a match
// HOLD    | match held; waiting for a button press or hold-timer expiry
// RELEASE | ack toggled; waiting for found_pattern to fall (bounded)
// DRAIN   | detector missed the release window; wait for it to go low

module pattern_ack_handler #(
   parameter int unsigned COUNT_W         = 8,
   parameter int unsigned HOLD_CYCLES     = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned RELEASE_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset_sync,
   input  logic               found_pattern,
   input  logic               btn_n,
   input  logic               auto_mode,
   input  logic               clear_count,
   output logic               ack,
   output logic               match_pulse,
   output logic [COUNT_W-1:0] match_count,
   output logic               busy,
   output logic               overflow,
   output logic               release_err
);

   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RW = $clog2(RELEASE_TIMEOUT);

   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LOAD  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] REL_LOAD  = RW'(RELEASE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   state_t        state;
   logic [HW-1:0] hold_tmr;
   logic [RW-1:0] rel_tmr;

   logic          btn_s1;
   logic          btn_s2;
   logic          btn_db;
   logic [DW-1:0] deb_cnt;
   logic          press_evt;

   // Button synchronizer and debouncer. The synchronizer and debounced level
   // reset to 1 (button released). The down-counter is reloaded whenever the
   // synchronized level agrees with the debounced level, so only an
   // uninterrupted run of DEBOUNCE_CYCLES disagreeing cycles reaches zero.
   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) begin
         btn_s1  <= 1'b1;
         btn_s2  <= 1'b1;
         btn_db  <= 1'b1;
         deb_cnt <= '0;
      end else begin
         btn_s1 <= btn_n;
         btn_s2 <= btn_s1;
         if (btn_s2 == btn_db) begin
            deb_cnt <= DEB_LOAD;
         end else if (deb_cnt == '0) begin
            btn_db  <= btn_s2;
            deb_cnt <= DEB_LOAD;
         end else begin
            deb_cnt <= deb_cnt - 1'b1;
         end
      end
   end

   // Strobe is high in the single cycle in which the debounced level is about
   // to flip from released to pressed. Release flips never produce a strobe.
   assign press_evt = (btn_s2 != btn_db) && (deb_cnt == '0) && !btn_s2;

   always_ff @(posedge clk or posedge reset_sync) begin
      if (reset_sync) begin
         state       <= ST_IDLE;
         hold_tmr    <= '0;
         rel_tmr     <= '0;
         ack         <= 1'b0;
         match_pulse <= 1'b0;
         match_count <= '0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
         release_err <= 1'b0;
      end else begin
         match_pulse <= 1'b0;

         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (found_pattern) begin
                  match_pulse <= 1'b1;
                  if (match_count == '1) begin
                     overflow <= 1'b1;
                  end else begin
                     match_count <= match_count + 1'b1;
                  end
                  hold_tmr <= HOLD_LOAD;
                  busy     <= 1'b1;
                  state    <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (!found_pattern) begin
                  // Detector was reset behind our back; nothing to acknowledge.
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (press_evt || (auto_mode && (hold_tmr == '0))) begin
                  ack     <= ~ack;
                  rel_tmr <= REL_LOAD;
                  state   <= ST_RELEASE;
               end else if (hold_tmr != '0) begin
                  hold_tmr <= hold_tmr - 1'b1;
               end
            end

            ST_RELEASE: begin
               if (!found_pattern) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (rel_tmr == '0) begin
                  release_err <= 1'b1;
                  state       <= ST_DRAIN;
               end else begin
                  rel_tmr <= rel_tmr - 1'b1;
               end
            end

            ST_DRAIN: begin
               if (!found_pattern) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase

         // Clear takes priority over a same-cycle match or error.
         if (clear_count) begin
            match_count <= '0;
            overflow    <= 1'b0;
            release_err <= 1'b0;
         end
      end
   end

endmodule
